// File: rtl/stoch_dot_prod_sched_if.sv
// Scheduler bus: requester side (req/len/u/v in, grant/done/y out) and the
// shared dot-product unit side (dp_* out, dp_y back in).
interface stoch_dot_prod_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int VEC_LEN = 2,
  parameter int LEN_W   = 16
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*LEN_W-1:0]   req_len;
  logic [NUM_REQ*VEC_LEN-1:0] u_in;
  logic [NUM_REQ*VEC_LEN-1:0] v_in;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;
  logic                       dp_nrst;
  logic [VEC_LEN-1:0]         dp_u;
  logic [VEC_LEN-1:0]         dp_v;
  logic                       dp_y;
  logic                       y_out;
  logic                       y_valid;
  logic [OWN_W-1:0]           y_owner;

  modport master (
    input  req, req_len, u_in, v_in, dp_y,
    output grant, done, busy, dp_nrst, dp_u, dp_v, y_out, y_valid, y_owner
  );

  modport slave (
    output req, req_len, u_in, v_in, dp_y,
    input  grant, done, busy, dp_nrst, dp_u, dp_v, y_out, y_valid, y_owner
  );
endinterface

// File: rtl/stoch_dot_prod_sched.sv
// Round-robin time-sharing of one stochastic dot-product unit; result bits leave in the
// same cycle their inputs are consumed, 3 cycles overhead per job, requesters hold req as a level.
module stoch_dot_prod_sched #(
  parameter int NUM_REQ = 4,
  parameter int VEC_LEN = 2,
  parameter int LEN_W   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  stoch_dot_prod_sched_if.master bus
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [OWN_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [OWN_W-1:0] r_owner, w_owner_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [OWN_W-1:0] w_winner, w_cand;
  logic [LEN_W-1:0] w_win_len;
  logic             w_found;
  int               w_idx;

  // First asserted request at or after the round-robin pointer, wrapping mod NUM_REQ.
  always_comb begin : rr_search
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = OWN_W'(w_idx);
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_win_len = bus.req_len[w_winner*LEN_W +: LEN_W];

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_winner;
          w_cnt_nxt   = w_win_len;
          w_state_nxt = (w_win_len == '0) ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: w_state_nxt = S_RUN;
      S_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == LEN_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_rr_nxt    = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The unit sees the owner's bits directly so y returns in the consuming cycle.
  always_comb begin : fsm_out
    bus.grant   = '0;
    bus.done    = '0;
    bus.dp_u    = '0;
    bus.dp_v    = '0;
    bus.y_out   = 1'b0;
    bus.y_valid = 1'b0;
    bus.busy    = (r_state != S_IDLE);
    bus.dp_nrst = ~i_rst & (r_state != S_FLUSH);
    bus.y_owner = r_owner;
    case (r_state)
      S_RUN: begin
        bus.grant   = NUM_REQ'(1) << r_owner;
        bus.dp_u    = bus.u_in[r_owner*VEC_LEN +: VEC_LEN];
        bus.dp_v    = bus.v_in[r_owner*VEC_LEN +: VEC_LEN];
        bus.y_out   = bus.dp_y;
        bus.y_valid = 1'b1;
      end
      S_DONE:  bus.done = NUM_REQ'(1) << r_owner;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end
endmodule
